tag_retire_table: RTL and testbench

Multi-port register tag table for the RV32EC issue stage: one entry per architectural register, holding the producer tag of the in-flight write and a pending bit. Successor to the write-addressed tagfile: independent read ports, tag-matched retirement that clears pending bits, global flush, same-cycle bypass, an occupancy counter and an allocation-collision flag. Register 0 never holds a tag.

---
 rtl/tag_retire_table.sv | 154 +++++++++++++++
 tb/tb_tag_retire_table.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tag_retire_table.sv
// Register tag table: per-register producer tag and pending bit, with tag-matched
// retirement, global flush, optional same-cycle bypass and optional buffered reads.
module tag_retire_table #(
    parameter int wr_ports  = 2,
    parameter int rd_ports  = 2,
    parameter int ret_ports = 2,
    parameter int addr_w    = 5,
    parameter int data_w    = 6,
    parameter int buf_read  = 0,
    parameter int bypass    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [wr_ports-1:0]           AllocEn,
    input  logic [wr_ports*addr_w-1:0]    AllocAddr,
    input  logic [wr_ports*data_w-1:0]    AllocTag,
    input  logic [ret_ports-1:0]          RetireEn,
    input  logic [ret_ports*data_w-1:0]   RetireTag,
    input  logic                          Flush,
    input  logic [rd_ports*addr_w-1:0]    RdAddr,
    output logic [rd_ports*data_w-1:0]    RdTag,
    output logic [rd_ports-1:0]           RdValid,
    output logic [addr_w:0]               PendingCnt,
    output logic                          AllocCollide
);

    localparam int N = 1 << addr_w;

    logic [N-1:0]        r_pend;
    logic [data_w-1:0]   r_tags [N];
    logic [addr_w:0]     r_cnt;
    logic                r_collide;

    logic [N-1:0]        w_pend_nxt;
    logic [data_w-1:0]   w_tags_nxt [N];
    logic [addr_w:0]     w_cnt_nxt;
    logic                w_collide;
    logic [N-1:0]        w_src_pend;
    logic [data_w-1:0]   w_src_tags [N];
    logic [rd_ports-1:0]        w_rd_valid;
    logic [rd_ports*data_w-1:0] w_rd_tag;

    // Retire compares against stored tags only, so an alloc in the same cycle
    // always overrides it; later alloc ports overwrite earlier ones.
    always_comb begin
        w_pend_nxt = r_pend;
        w_tags_nxt = r_tags;
        for (int e = 1; e < N; e++) begin
            for (int j = 0; j < ret_ports; j++) begin
                if (r_pend[e] && RetireEn[j] &&
                    (RetireTag[j*data_w +: data_w] == r_tags[e])) begin
                    w_pend_nxt[e] = 1'b0;
                end
            end
        end
        for (int i = 0; i < wr_ports; i++) begin
            if (AllocEn[i] && (AllocAddr[i*addr_w +: addr_w] != '0)) begin
                w_tags_nxt[AllocAddr[i*addr_w +: addr_w]] = AllocTag[i*data_w +: data_w];
                w_pend_nxt[AllocAddr[i*addr_w +: addr_w]] = 1'b1;
            end
        end
        if (Flush) begin
            w_pend_nxt = '0;
            w_tags_nxt = r_tags;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_comb begin
        w_collide = 1'b0;
        for (int i = 0; i < wr_ports; i++) begin
            for (int j = i + 1; j < wr_ports; j++) begin
                if (AllocEn[i] && AllocEn[j] &&
                    (AllocAddr[i*addr_w +: addr_w] == AllocAddr[j*addr_w +: addr_w]) &&
                    (AllocAddr[i*addr_w +: addr_w] != '0)) begin
                    w_collide = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int e = 1; e < N; e++) begin
            w_cnt_nxt = w_cnt_nxt + {{addr_w{1'b0}}, w_pend_nxt[e]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend    <= '0;
            r_cnt     <= '0;
            r_collide <= 1'b0;
        end else begin
            r_pend    <= w_pend_nxt;
            r_cnt     <= w_cnt_nxt;
            r_collide <= w_collide;
        end
    end

    // Tags carry no reset; they are only observable through a set pending bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tags <= w_tags_nxt;
        end
    end

    assign w_src_pend = (bypass != 0) ? w_pend_nxt : r_pend;

    always_comb begin
        for (int e = 0; e < N; e++) begin
            w_src_tags[e] = (bypass != 0) ? w_tags_nxt[e] : r_tags[e];
        end
    end

    always_comb begin
        w_rd_valid = '0;
        w_rd_tag   = '0;
        for (int k = 0; k < rd_ports; k++) begin
            if ((RdAddr[k*addr_w +: addr_w] != '0) && w_src_pend[RdAddr[k*addr_w +: addr_w]]) begin
                w_rd_valid[k]                 = 1'b1;
                w_rd_tag[k*data_w +: data_w]  = w_src_tags[RdAddr[k*addr_w +: addr_w]];
            end
        end
    end

    generate
        if (buf_read != 0) begin : g_buf
            logic [rd_ports-1:0]        r_rd_valid;
            logic [rd_ports*data_w-1:0] r_rd_tag;

            // A flush empties the table, so the buffered view is blanked with it.
            always_ff @(posedge clk) begin
                if (rst || Flush) begin
                    r_rd_valid <= '0;
                    r_rd_tag   <= '0;
                end else begin
                    r_rd_valid <= w_rd_valid;
                    r_rd_tag   <= w_rd_tag;
                end
            end

            assign RdValid = r_rd_valid;
            assign RdTag   = r_rd_tag;
        end else begin : g_comb
            assign RdValid = w_rd_valid;
            assign RdTag   = w_rd_tag;
        end
    endgenerate

    assign PendingCnt   = r_cnt;
    assign AllocCollide = r_collide;

endmodule

// File: tb/tb_tag_retire_table.sv
// Directed table-driven bench: three instances (bypass comb, bypass buffered,
// registered comb) share stimulus and are compared against hand-computed values.
module tb_tag_retire_table;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  AllocEn;
    logic [9:0]  AllocAddr;
    logic [11:0] AllocTag;
    logic [1:0]  RetireEn;
    logic [11:0] RetireTag;
    logic        Flush;
    logic [9:0]  RdAddr;

    logic [11:0] tag_a, tag_b, tag_c;
    logic [1:0]  val_a, val_b, val_c;
    logic [5:0]  cnt_a, cnt_b, cnt_c;
    logic        col_a, col_b, col_c;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    tag_retire_table #(.buf_read(0), .bypass(1)) dut_a (
        .clk(clk), .rst(rst), .AllocEn(AllocEn), .AllocAddr(AllocAddr), .AllocTag(AllocTag),
        .RetireEn(RetireEn), .RetireTag(RetireTag), .Flush(Flush), .RdAddr(RdAddr),
        .RdTag(tag_a), .RdValid(val_a), .PendingCnt(cnt_a), .AllocCollide(col_a));

    tag_retire_table #(.buf_read(1), .bypass(1)) dut_b (
        .clk(clk), .rst(rst), .AllocEn(AllocEn), .AllocAddr(AllocAddr), .AllocTag(AllocTag),
        .RetireEn(RetireEn), .RetireTag(RetireTag), .Flush(Flush), .RdAddr(RdAddr),
        .RdTag(tag_b), .RdValid(val_b), .PendingCnt(cnt_b), .AllocCollide(col_b));

    tag_retire_table #(.buf_read(0), .bypass(0)) dut_c (
        .clk(clk), .rst(rst), .AllocEn(AllocEn), .AllocAddr(AllocAddr), .AllocTag(AllocTag),
        .RetireEn(RetireEn), .RetireTag(RetireTag), .Flush(Flush), .RdAddr(RdAddr),
        .RdTag(tag_c), .RdValid(val_c), .PendingCnt(cnt_c), .AllocCollide(col_c));

    typedef struct {
        int aen; int a0; int t0; int a1; int t1;
        int ren; int rt0; int rt1; int fl; int r0; int r1;
        int av; int at0; int at1;
        int cv; int ct0; int ct1;
        int cnt; int col;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int aen, input int a0, input int t0, input int a1, input int t1,
                         input int ren, input int rt0, input int rt1, input int fl,
                         input int r0, input int r1);
        AllocEn   = aen[1:0];
        AllocAddr = {a1[4:0], a0[4:0]};
        AllocTag  = {t1[5:0], t0[5:0]};
        RetireEn  = ren[1:0];
        RetireTag = {rt1[5:0], rt0[5:0]};
        Flush     = fl[0];
        RdAddr    = {r1[4:0], r0[4:0]};
    endtask

    task automatic chk_reads(input string nm, input logic [1:0] v, input logic [11:0] t,
                             input int ev, input int et0, input int et1);
        chk({nm, "_valid"}, int'(v), ev);
        chk({nm, "_tag0"}, int'(t[5:0]), et0);
        chk({nm, "_tag1"}, int'(t[11:6]), et1);
    endtask

    task automatic chk_counts(input string nm, input int ecnt, input int ecol);
        chk({nm, "_cnt_a"}, int'(cnt_a), ecnt);
        chk({nm, "_cnt_b"}, int'(cnt_b), ecnt);
        chk({nm, "_cnt_c"}, int'(cnt_c), ecnt);
        chk({nm, "_collide"}, int'(col_a), ecol);
        chk({nm, "_collide_c"}, int'(col_c), ecol);
    endtask

    initial begin
        int pv, pt0, pt1;
        string nm;

        //            aen a0 t0  a1 t1  ren rt0 rt1 fl r0 r1  av at0 at1 cv ct0 ct1 cnt col
        vecs[0]  = '{0, 0, 0,  0, 0,  0, 0,  0,  0, 5, 0,  0, 0,  0,  0, 0,  0,  0, 0};
        vecs[1]  = '{1, 0, 7,  0, 0,  0, 0,  0,  0, 0, 5,  0, 0,  0,  0, 0,  0,  0, 0};
        vecs[2]  = '{1, 3, 12, 0, 0,  0, 0,  0,  0, 3, 5,  1, 12, 0,  0, 0,  0,  0, 0};
        vecs[3]  = '{0, 0, 0,  0, 0,  0, 0,  0,  0, 3, 3,  3, 12, 12, 3, 12, 12, 1, 0};
        vecs[4]  = '{3, 4, 9,  6, 9,  0, 0,  0,  0, 4, 6,  3, 9,  9,  0, 0,  0,  1, 0};
        vecs[5]  = '{0, 0, 0,  0, 0,  1, 9,  0,  0, 4, 6,  0, 0,  0,  3, 9,  9,  3, 0};
        vecs[6]  = '{1, 3, 20, 0, 0,  2, 0,  12, 0, 3, 4,  1, 20, 0,  1, 12, 0,  1, 0};
        vecs[7]  = '{3, 7, 1,  7, 2,  0, 0,  0,  0, 7, 3,  3, 2,  20, 2, 0,  20, 1, 0};
        vecs[8]  = '{0, 0, 0,  0, 0,  0, 0,  0,  0, 7, 3,  3, 2,  20, 3, 2,  20, 2, 1};
        vecs[9]  = '{1, 8, 5,  0, 0,  0, 0,  0,  1, 8, 7,  0, 0,  0,  2, 0,  2,  2, 0};
        vecs[10] = '{0, 0, 0,  0, 0,  0, 0,  0,  0, 8, 7,  0, 0,  0,  0, 0,  0,  0, 0};
        vecs[11] = '{1, 9, 33, 0, 0,  1, 33, 0,  0, 9, 9,  3, 33, 33, 0, 0,  0,  0, 0};
        vecs[12] = '{2, 0, 0, 10, 33, 1, 33, 0,  0, 9, 10, 2, 0,  33, 1, 33, 0,  1, 0};
        vecs[13] = '{0, 0, 0,  0, 0,  0, 0,  0,  0, 9, 10, 2, 0,  33, 2, 0,  33, 1, 0};
        vecs[14] = '{3, 0, 4,  0, 3,  0, 0,  0,  0, 10, 0, 1, 33, 0,  1, 33, 0,  1, 0};
        vecs[15] = '{0, 0, 0,  0, 0,  0, 0,  0,  0, 10, 31, 1, 33, 0, 1, 33, 0,  1, 0};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reads("reset_a", val_a, tag_a, 0, 0, 0);
        chk_reads("reset_b", val_b, tag_b, 0, 0, 0);
        chk_counts("reset", 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // The buffered instance shows the previous cycle's bypass result.
        pv = 0; pt0 = 0; pt1 = 0;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk);
            #1;
            drive(vecs[n].aen, vecs[n].a0, vecs[n].t0, vecs[n].a1, vecs[n].t1,
                  vecs[n].ren, vecs[n].rt0, vecs[n].rt1, vecs[n].fl, vecs[n].r0, vecs[n].r1);
            @(negedge clk);
            nm = $sformatf("v%0d", n);
            chk_reads({nm, "_a"}, val_a, tag_a, vecs[n].av, vecs[n].at0, vecs[n].at1);
            chk_reads({nm, "_c"}, val_c, tag_c, vecs[n].cv, vecs[n].ct0, vecs[n].ct1);
            chk_reads({nm, "_b"}, val_b, tag_b, pv, pt0, pt1);
            chk_counts(nm, vecs[n].cnt, vecs[n].col);
            pv = vecs[n].av; pt0 = vecs[n].at0; pt1 = vecs[n].at1;
        end

        // Reset asserted mid-operation with an alloc that must be ignored.
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 10, 12);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 12);
        @(negedge clk);
        chk_reads("midrst_a", val_a, tag_a, 0, 0, 0);
        chk_reads("midrst_b", val_b, tag_b, 0, 0, 0);
        chk_reads("midrst_c", val_c, tag_c, 0, 0, 0);
        chk_counts("midrst", 0, 0);

        // Fill every entry 1..31, two per cycle, tag equal to address.
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1 drive((i == 15) ? 1 : 3, 2*i+1, 2*i+1, 2*i+2, 2*i+2, 0, 0, 0, 0, 0, 0);
        end
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 1);
        @(negedge clk);
        chk_counts("full", 31, 0);
        chk_reads("full_c", val_c, tag_c, 3, 31, 1);

        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 1);
        @(negedge clk);
        chk_reads("flush_b_pre", val_b, tag_b, 3, 31, 1);
        chk_reads("flush_a", val_a, tag_a, 0, 0, 0);
        chk_reads("flush_c", val_c, tag_c, 3, 31, 1);
        chk_counts("flush_pre", 31, 0);

        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 31, 1);
        @(negedge clk);
        chk_reads("flush_b", val_b, tag_b, 0, 0, 0);
        chk_reads("flush_c_post", val_c, tag_c, 0, 0, 0);
        chk_counts("flush_post", 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
